// File: rtl/fp32_pkg.sv
// Shared constants and enumerated types for the FP32 add/normalize datapath.
package fp32_pkg;

    localparam int EXP_W      = 8;
    localparam int EXT_MANT_W = 27;
    localparam int EXP_MAX    = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

    typedef enum logic [2:0] {
        ZERO       = 3'd0,
        CARRY      = 3'd1,
        NORM       = 3'd2,
        SPECIAL    = 3'd3,
        NEED_SHIFT = 3'd4
    } norm_class_e;

endpackage

// File: rtl/fp32_normalizer_norm_step.sv
// One left-normalization step: shifted mantissa, decremented exponent and a stop flag.
// Stop looks one step ahead so the shift that lands the leading one also ends the sequence.
module norm_step #(
    parameter int EXP_W      = 8,
    parameter int EXT_MANT_W = 27
) (
    input  logic [EXT_MANT_W-1:0] cur_mant,
    input  logic [EXP_W-1:0]      cur_exp,
    output logic [EXT_MANT_W-1:0] next_mant,
    output logic [EXP_W-1:0]      next_exp,
    output logic                  stop
);

    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    logic [EXT_MANT_W-1:0] shl_mant;
    logic [EXP_W-1:0]      dec_exp;

    assign shl_mant = {cur_mant[EXT_MANT_W-2:0], 1'b0};
    assign dec_exp  = cur_exp - EXP_ONE;

    always_comb begin
        next_mant = cur_mant;
        next_exp  = cur_exp;
        stop      = 1'b0;
        if (cur_mant[EXT_MANT_W-1]) begin
            stop = 1'b1;
        end else if (cur_exp <= EXP_ONE) begin
            stop     = 1'b1;
            next_exp = '0;
        end else begin
            next_mant = shl_mant;
            next_exp  = dec_exp;
            // Reaching exponent 1 without a leading one means the result is subnormal.
            if (shl_mant[EXT_MANT_W-1]) begin
                stop = 1'b1;
            end else if (dec_exp == EXP_ONE) begin
                stop     = 1'b1;
                next_exp = '0;
            end
        end
    end

endmodule

// File: rtl/fp32_normalizer.sv
// Post-add normalizer: one right shift on carry-out, otherwise one left shift per cycle
// until the leading one reaches the top bit or the exponent floors at the subnormal boundary.
//
// state | meaning
// IDLE  | no result held, ready for an operand
// SHIFT | removing leading zeros, one bit per cycle
// DONE  | result valid, held until out_ready
module fp32_normalizer
    import fp32_pkg::norm_state_e, fp32_pkg::IDLE, fp32_pkg::SHIFT, fp32_pkg::DONE,
           fp32_pkg::norm_class_e, fp32_pkg::ZERO, fp32_pkg::CARRY, fp32_pkg::NORM,
           fp32_pkg::SPECIAL, fp32_pkg::NEED_SHIFT;
#(
    parameter int EXP_W      = fp32_pkg::EXP_W,
    parameter int EXT_MANT_W = fp32_pkg::EXT_MANT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [EXT_MANT_W:0]   in_mant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [EXP_W-1:0]      out_exp,
    output logic [EXT_MANT_W-1:0] out_ext_mant,
    output logic                  out_zero,
    output logic                  out_overflow
);

    localparam logic [EXP_W:0] EXP_ONE_X = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] EXP_SAT_X = {1'b0, {EXP_W{1'b1}}};

    norm_state_e           state;
    norm_class_e           cls;
    logic                  accept;
    logic                  sign_q, zero_q, ovf_q;
    logic [EXP_W-1:0]      exp_q;
    logic [EXT_MANT_W-1:0] mant_q;

    logic [EXP_W:0]        exp_eff, exp_inc;
    logic [EXT_MANT_W-1:0] carry_mant;

    norm_state_e           ld_state;
    logic [EXP_W-1:0]      ld_exp;
    logic [EXT_MANT_W-1:0] ld_mant;
    logic                  ld_zero, ld_ovf;

    logic [EXT_MANT_W-1:0] step_mant;
    logic [EXP_W-1:0]      step_exp;
    logic                  step_stop;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Exponent 0 on input is treated as 1 so subnormal sums share the normal path.
    assign exp_eff    = (in_exp == '0) ? EXP_ONE_X : {1'b0, in_exp};
    assign exp_inc    = exp_eff + EXP_ONE_X;
    assign carry_mant = {in_mant[EXT_MANT_W:2], in_mant[1] | in_mant[0]};

    always_comb begin
        if (in_exp == EXP_SAT_X[EXP_W-1:0])
            cls = SPECIAL;
        else if (in_mant == '0)
            cls = ZERO;
        else if (in_mant[EXT_MANT_W])
            cls = CARRY;
        else if (in_mant[EXT_MANT_W-1])
            cls = NORM;
        else
            cls = NEED_SHIFT;
    end

    always_comb begin
        ld_state = DONE;
        ld_exp   = exp_eff[EXP_W-1:0];
        ld_mant  = in_mant[EXT_MANT_W-1:0];
        ld_zero  = 1'b0;
        ld_ovf   = 1'b0;
        case (cls)
            SPECIAL: ld_exp = in_exp;
            ZERO: begin
                ld_exp  = '0;
                ld_mant = '0;
                ld_zero = 1'b1;
            end
            CARRY: begin
                if (exp_inc >= EXP_SAT_X) begin
                    ld_exp  = EXP_SAT_X[EXP_W-1:0];
                    ld_mant = '0;
                    ld_ovf  = 1'b1;
                end else begin
                    ld_exp  = exp_inc[EXP_W-1:0];
                    ld_mant = carry_mant;
                end
            end
            NORM:       ;
            NEED_SHIFT: ld_state = SHIFT;
            default:    ;
        endcase
    end

    norm_step #(
        .EXP_W      (EXP_W),
        .EXT_MANT_W (EXT_MANT_W)
    ) u_norm_step (
        .cur_mant  (mant_q),
        .cur_exp   (exp_q),
        .next_mant (step_mant),
        .next_exp  (step_exp),
        .stop      (step_stop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            state  <= ld_state;
            sign_q <= in_sign;
            exp_q  <= ld_exp;
            mant_q <= ld_mant;
            zero_q <= ld_zero;
            ovf_q  <= ld_ovf;
        end else begin
            case (state)
                SHIFT: begin
                    mant_q <= step_mant;
                    exp_q  <= step_exp;
                    if (step_stop)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign out_valid    = (state == DONE);
    assign out_sign     = sign_q;
    assign out_exp      = exp_q;
    assign out_ext_mant = mant_q;
    assign out_zero     = zero_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fp32_normalizer.sv
// Directed and randomized checks of fp32_normalizer against an arithmetic reference model.
module tb_fp32_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [26:0] out_ext_mant;
    logic        out_zero, out_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  got_exp;
    logic [26:0] got_mant;
    logic        got_zero, got_ovf;
    int          got_lat, got_rdy_bad;

    always #5 clk = ~clk;

    fp32_normalizer #(
        .EXP_W      (8),
        .EXT_MANT_W (27)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_ext_mant (out_ext_mant),
        .out_zero     (out_zero),
        .out_overflow (out_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    // Reference: value-level normalization using plain integer arithmetic.
    function automatic void model(input logic [7:0] e, input logic [27:0] m,
                                  output logic [7:0] re, output logic [26:0] rm,
                                  output logic rz, output logic ro, output int lat);
        longint mm, ee;
        int     k;
        mm  = longint'(m);
        ee  = (e == 8'd0) ? 64'd1 : longint'(e);
        re  = 8'd0;
        rm  = 27'd0;
        rz  = 1'b0;
        ro  = 1'b0;
        lat = 1;
        if (e == 8'd255) begin
            re = 8'd255;
            rm = m[26:0];
        end else if (mm == 0) begin
            rz = 1'b1;
        end else if (mm >= 64'h8000000) begin
            if (ee + 1 >= 255) begin
                ro = 1'b1;
                re = 8'd255;
            end else begin
                re = 8'(ee + 1);
                rm = 27'((mm / 2) | (mm % 2));
            end
        end else begin
            k = 0;
            while (mm < 64'h4000000 && ee > 1) begin
                mm = mm * 2;
                ee = ee - 1;
                k++;
            end
            rm  = 27'(mm);
            re  = (mm >= 64'h4000000) ? 8'(ee) : 8'd0;
            lat = (k == 0 && mm < 64'h4000000) ? 2 : 1 + k;
        end
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m);
        logic [7:0]  re;
        logic [26:0] rm;
        logic        rz, ro;
        int          lat, n, rdy_bad;
        model(e, m, re, rm, rz, ro, lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_sign  = ~s;
        in_exp   = 8'($urandom);
        in_mant  = 28'($urandom);
        n = 1;
        rdy_bad = 0;
        while (!out_valid && n < 64) begin
            if (in_ready) rdy_bad++;
            tick();
            n++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " sign"}, 32'(out_sign), 32'(s));
        check({tag, " exp"}, 32'(out_exp), 32'(re));
        check({tag, " mant"}, 32'(out_ext_mant), 32'(rm));
        check({tag, " zero"}, 32'(out_zero), 32'(rz));
        check({tag, " ovf"}, 32'(out_overflow), 32'(ro));
        got_exp     = out_exp;
        got_mant    = out_ext_mant;
        got_zero    = out_zero;
        got_ovf     = out_overflow;
        got_lat     = n;
        got_rdy_bad = rdy_bad;
        tick();
    endtask

    logic [7:0]  re_b;
    logic [26:0] rm_b;
    logic        rz_b, ro_b;
    int          lat_b, bad;
    logic [7:0]  r_e;
    logic [27:0] r_m;
    logic [63:0] lo;
    int          p;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_exp    = 8'h40;
        in_mant   = 28'h4000000;
        out_ready = 1'b1;

        // Reset held with a valid operand pending: nothing is accepted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst out_valid", 32'(out_valid), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid idle", 32'(out_valid), 32'd0);
        check("rst sign", 32'(out_sign), 32'd0);
        check("rst exp", 32'(out_exp), 32'd0);
        check("rst mant", 32'(out_ext_mant), 32'd0);
        check("rst zero", 32'(out_zero), 32'd0);
        check("rst ovf", 32'(out_overflow), 32'd0);

        run_op("carry", 1'b0, 8'h80, 28'h8000007);
        check("carry exp const", 32'(got_exp), 32'h81);
        check("carry mant const", 32'(got_mant), 32'h4000003);

        run_op("ovf", 1'b1, 8'hFE, 28'h8000000);
        check("ovf flag const", 32'(got_ovf), 32'd1);
        check("ovf exp const", 32'(got_exp), 32'hFF);
        check("ovf mant const", 32'(got_mant), 32'd0);

        run_op("cancel", 1'b0, 8'h80, 28'h0000800);
        check("cancel latency const", 32'(got_lat), 32'd16);
        check("cancel exp const", 32'(got_exp), 32'h71);
        check("cancel mant const", 32'(got_mant), 32'h4000000);
        check("cancel in_ready low", 32'(got_rdy_bad), 32'd0);

        run_op("subn", 1'b0, 8'h03, 28'h0100000);
        check("subn exp const", 32'(got_exp), 32'd0);
        check("subn mant const", 32'(got_mant), 32'h0400000);

        run_op("zero", 1'b1, 8'h55, 28'h0000000);
        check("zero flag const", 32'(got_zero), 32'd1);
        check("zero latency const", 32'(got_lat), 32'd1);

        run_op("special", 1'b0, 8'hFF, 28'h0ABCDEF);
        check("special mant const", 32'(got_mant), 32'h0ABCDEF);

        // Backpressure: DONE holds while out_ready is low, new inputs ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_exp    = 8'h40;
        in_mant   = 28'h5000000;
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_exp  = 8'($urandom);
            in_mant = 28'($urandom);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sign !== 1'b1 ||
                out_exp !== 8'h40 || out_ext_mant !== 27'h5000000 || out_zero !== 1'b0)
                bad++;
            tick();
        end
        check("bp hold stable", 32'(bad), 32'd0);
        in_sign   = 1'b0;
        in_exp    = 8'h22;
        in_mant   = 28'h4ABCDEF;
        out_ready = 1'b1;
        #1;
        check("bp same-cycle ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp next valid", 32'(out_valid), 32'd1);
        check("bp next exp", 32'(out_exp), 32'h22);
        check("bp next mant", 32'(out_ext_mant), 32'h4ABCDEF);
        tick();
        check("bp drained", 32'(out_valid), 32'd0);

        // Back-to-back normalized operands, one result per cycle.
        for (int i = 0; i < 6; i++) begin
            r_e      = 8'($urandom_range(1, 254));
            r_m      = {2'b01, 26'($urandom)};
            in_valid = 1'b1;
            in_sign  = 1'($urandom);
            in_exp   = r_e;
            in_mant  = r_m;
            model(r_e, r_m, re_b, rm_b, rz_b, ro_b, lat_b);
            tick();
            check("b2b valid", 32'(out_valid), 32'd1);
            check("b2b exp", 32'(out_exp), 32'(re_b));
            check("b2b mant", 32'(out_ext_mant), 32'(rm_b));
        end
        in_valid = 1'b0;
        tick();

        // Reset in the 10th cycle of a 15-shift operation.
        in_valid = 1'b1;
        in_exp   = 8'h80;
        in_mant  = 28'h0000800;
        tick();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        check("midrst no valid", 32'(bad), 32'd0);
        run_op("post rst", 1'b0, 8'h7F, 28'h4000000);
        check("post rst exp const", 32'(got_exp), 32'h7F);
        check("post rst mant const", 32'(got_mant), 32'h4000000);
        check("post rst latency const", 32'(got_lat), 32'd1);

        // Randomized operands across all classes.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0:       r_e = 8'd0;
                1:       r_e = 8'd255;
                2:       r_e = 8'd254;
                3, 4:    r_e = 8'($urandom_range(1, 6));
                default: r_e = 8'($urandom_range(1, 254));
            endcase
            p  = int'($urandom_range(0, 28));
            lo = {$urandom, $urandom};
            if (p == 28) r_m = 28'd0;
            else         r_m = 28'((64'd1 << p) | (lo & ((64'd1 << p) - 64'd1)));
            run_op("rand", 1'($urandom), r_e, r_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp32_normalizer.md
# fp32_normalizer

Iterative post-add normalization stage for the FP32 datapath. It accepts the raw 28-bit mantissa sum (carry bit plus 24-bit significand plus G/R/S) with its exponent and sign. It then right-shifts once on carry-out, or left-shifts one bit per cycle to remove leading zeros. The output is a normalized 27-bit extended mantissa and an adjusted exponent, in exactly the form the rounding stage consumes.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- EXT_MANT_W, 27, extended mantissa width (24 significand + G, R, S)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand this cycle
- in_sign  in  1  sign of sum
- in_exp  in  EXP_W  biased exponent of sum
- in_mant  in  EXT_MANT_W+1  raw sum; bit 27 = carry-out, bits [2:0] = G, R, S
- out_valid  out  1  normalized result valid
- out_ready  in  1  downstream accepts result
- out_sign  out  1  sign, passed through
- out_exp  out  EXP_W  adjusted biased exponent (0 = subnormal or zero)
- out_ext_mant  out  EXT_MANT_W  normalized mantissa with G, R, S
- out_zero  out  1  result is exact zero
- out_overflow  out  1  exponent saturated to 255; result is infinity

## Operation
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A transfer occurs on in_valid && in_ready.
- On accept, the operand is latched and classified in the same cycle. The effective exponent is max(in_exp, 1).
  - in_exp==255: pass through unchanged (mant[26:0], exp 255), flags 0 -> DONE.
  - in_mant==0: exp 0, mant 0, out_zero=1 -> DONE.
  - in_mant[27]==1:
    - mant = in_mant[27:1] with bit0 = in_mant[1]|in_mant[0] (sticky preserved); exp+1.
    - If the new exp is 255: out_overflow=1, mant forced to 0 -> DONE.
  - in_mant[26]==1: no change -> DONE.
  - Otherwise -> SHIFT.
- SHIFT, each cycle:
  - If mant[26]==1: -> DONE.
  - Else if exp==1: -> DONE with out_exp=0 (subnormal floor).
  - Else: mant <<= 1 (0 shifted into bit0); exp -= 1.
- DONE: out_valid=1 and all outputs held stable until out_ready.
  - On out_ready with no new accept: -> IDLE.
  - On out_ready with a simultaneous accept: classify the new operand -> DONE or SHIFT.
- Exponent arithmetic is done in EXP_W+1 bits internally to detect carry into 255. A left shift never decrements below 1.
- Flags out_zero and out_overflow are mutually exclusive. Both are valid only while out_valid.

## Timing
- Reset: state IDLE, out_valid=0, out_sign=0, out_exp=0, out_ext_mant=0, out_zero=0, out_overflow=0. in_ready=1 on the first cycle after reset deasserts.
- rst mid-operation aborts any SHIFT or DONE. The pending result is discarded and not emitted.
- Latency from accept edge to out_valid:
  - 1 cycle for the zero, carry, already-normalized and special cases.
  - 1+k cycles for k left shifts, with k ≤ 26.
- Back-to-back throughput: one result per cycle is possible when no shifts are needed and out_ready stays high.
- Backpressure: with out_ready low, DONE holds indefinitely with outputs unchanged and in_ready=0.
- in_* are sampled only on the accept edge. Changes to in_* at other times are ignored.

## Structure
- Shared package fp32_pkg holds:
  - EXP_W, EXT_MANT_W, EXP_MAX (255) constants.
  - The state enum type (IDLE, SHIFT, DONE).
  - The classification enum (ZERO, CARRY, NORM, SPECIAL, NEED_SHIFT).
- One combinational sub-module, norm_step, computes a single left-shift step: next mant, next exp, and a stop condition. SHIFT uses it; the FSM and registers stay in fp32_normalizer.

## Test plan
- Reset and idle:
  - Assert rst for 3 cycles, then release -> out_valid=0, all outputs 0, in_ready=1.
  - With in_valid held high during rst, no operand is accepted.
- Carry case:
  - Input exp=0x80, mant=0x8000007 -> next cycle out_exp=0x81, out_ext_mant=0x4000003.
  - Input exp=0xFE, mant=0x8000000 -> out_exp=0xFF, out_ext_mant=0, out_overflow=1.
- Cancellation:
  - Input exp=0x80, mant=0x0000800 (bit 11) -> out_valid 16 cycles after accept.
  - Result: out_exp=0x71, out_ext_mant=0x4000000, in_ready=0 throughout.
- Subnormal floor and zero:
  - Input exp=0x03, mant=0x0100000 -> out_ext_mant=0x0400000, out_exp=0x00 after 2 shifts.
  - Input mant=0 -> out_zero=1, out_exp=0, latency 1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - Raise out_ready with in_valid high and a normalized operand -> same-cycle accept; new result valid the next cycle.
- Mid-operation reset:
  - Pulse rst during the 10th cycle of a 15-shift operation -> no out_valid is ever asserted for that operand.
  - A following operand (exp=0x7F, mant=0x4000000) returns unchanged after 1 cycle.
